// File: rtl/cnn_mem_pkg.sv
// Shared types and constants for the CNN memory subsystem and layer sequencer.
package cnn_mem_pkg;
  typedef enum logic [1:0] {LOAD, START, WAIT, DONE} seq_state_e;

  localparam logic [3:0] REG_CTRL = 4'hF;
  localparam logic [3:0] REG_OUT  = 4'hE;
  localparam logic [3:0] REG_STAT = 4'hD;

  localparam int unsigned DEF_REGION_SIZE [5] = '{10000, 400, 12800, 230400, 10600};
endpackage

// File: rtl/cnn_mem_bank.sv
// Simple dual-port RAM: synchronous write, registered read (read-before-write on collision).
module cnn_mem_bank #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/cnn_seq_mem.sv
// Host-loadable image/weight banks, output bank and layer sequencer for the blackjack-counter CNN.
module cnn_seq_mem
  import cnn_mem_pkg::*;
#(
  parameter int          DATA_W     = 8,
  parameter int          NUM_LAYERS = 4,
  parameter int          SEL_W      = 4,
  parameter int          ADDR_W     = 19,
  parameter int          DEPTH_W    = 18,
  parameter int unsigned REGION_SIZE [NUM_LAYERS+1] = DEF_REGION_SIZE,
  parameter int          OUT_SIZE   = 16384
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chipselect,
  input  logic                  write,
  input  logic                  read,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     writedata,
  output logic [DATA_W-1:0]     readdata,
  output logic                  readdatavalid,
  output logic [NUM_LAYERS-1:0] layer_start,
  input  logic [NUM_LAYERS-1:0] layer_done,
  input  logic                  lyr_rd_en,
  input  logic [SEL_W-1:0]      lyr_rd_region,
  input  logic [DEPTH_W-1:0]    lyr_rd_addr,
  output logic [DATA_W-1:0]     lyr_rd_data,
  input  logic                  lyr_wr_en,
  input  logic [DEPTH_W-1:0]    lyr_wr_addr,
  input  logic [DATA_W-1:0]     lyr_wr_data,
  output logic [NUM_LAYERS:0]   loaded,
  output logic                  busy,
  output logic                  result_ready,
  output logic                  wr_err
);
  localparam int NB    = NUM_LAYERS + 1;
  localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int OAW   = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

  seq_state_e state, state_d;
  logic [IDX_W-1:0]             idx, idx_d;
  logic [NB-1:0][DEPTH_W-1:0]   ptr;
  logic [NB-1:0][DATA_W-1:0]    bank_q;
  logic [NB-1:0]                bank_we, rd_hit, rd_hit_q;
  logic [SEL_W-1:0]             sel;
  logic                         wr_acc, rd_acc, ctrl_clr, wr_drop;
  logic                         out_re, out_we, out_hit_q;
  logic [DATA_W-1:0]            out_q, stat_q;
  logic                         unused_addr;

  assign sel         = address[ADDR_W-1 -: SEL_W];
  assign wr_acc      = chipselect && write;
  assign rd_acc      = chipselect && read && !write;
  assign ctrl_clr    = wr_acc && (sel == SEL_W'(REG_CTRL)) && writedata[0];
  assign wr_drop     = wr_acc && (sel != SEL_W'(REG_CTRL)) && !(|bank_we);
  assign unused_addr = ^address;

  for (genvar g = 0; g < NB; g++) begin : g_bank
    localparam int AW = (REGION_SIZE[g] > 1) ? $clog2(REGION_SIZE[g]) : 1;
    // A full bank refuses further writes; the pointer never wraps.
    assign bank_we[g] = wr_acc && (sel == SEL_W'(g)) && (state == LOAD) && !loaded[g];
    assign rd_hit[g]  = lyr_rd_en && (lyr_rd_region == SEL_W'(g)) &&
                        (lyr_rd_addr < DEPTH_W'(REGION_SIZE[g]));
    cnn_mem_bank #(.DEPTH(int'(REGION_SIZE[g])), .DATA_W(DATA_W), .AW(AW)) u_bank (
      .clk   (clk),
      .we    (bank_we[g]),
      .waddr (ptr[g][AW-1:0]),
      .wdata (writedata),
      .re    (rd_hit[g]),
      .raddr (lyr_rd_addr[AW-1:0]),
      .rdata (bank_q[g])
    );
  end

  assign out_we = lyr_wr_en && (state == WAIT) && (lyr_wr_addr < DEPTH_W'(OUT_SIZE));
  assign out_re = rd_acc && (sel == SEL_W'(REG_OUT)) && (int'(address[OAW-1:0]) < OUT_SIZE);

  cnn_mem_bank #(.DEPTH(OUT_SIZE), .DATA_W(DATA_W), .AW(OAW)) u_out (
    .clk   (clk),
    .we    (out_we),
    .waddr (lyr_wr_addr[OAW-1:0]),
    .wdata (lyr_wr_data),
    .re    (out_re),
    .raddr (address[OAW-1:0]),
    .rdata (out_q)
  );

  always_ff @(posedge clk) begin
    if (!reset || ctrl_clr) begin
      ptr    <= '0;
      loaded <= '0;
    end else begin
      for (int i = 0; i < NB; i++)
        if (bank_we[i]) begin
          if (ptr[i] == DEPTH_W'(REGION_SIZE[i] - 1)) loaded[i] <= 1'b1;
          else ptr[i] <= ptr[i] + 1'b1;
        end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || ctrl_clr) wr_err <= 1'b0;
    else if (wr_drop)       wr_err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= LOAD;
      idx   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  // Only the running layer's done bit is observed; others are ignored.
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    layer_start = '0;
    case (state)
      LOAD:  if (&loaded) begin
               state_d = START;
               idx_d   = '0;
             end
      START: begin
               layer_start[idx] = 1'b1;
               state_d          = WAIT;
             end
      WAIT:  if (layer_done[idx]) begin
               if (idx == IDX_W'(NUM_LAYERS - 1)) state_d = DONE;
               else begin
                 idx_d   = idx + 1'b1;
                 state_d = START;
               end
             end
      DONE:  ;
      default: state_d = LOAD;
    endcase
    if (ctrl_clr) begin
      state_d = LOAD;
      idx_d   = '0;
    end
  end

  assign busy         = (state == START) || (state == WAIT);
  assign result_ready = (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      readdatavalid <= 1'b0;
      out_hit_q     <= 1'b0;
      stat_q        <= '0;
      rd_hit_q      <= '0;
    end else begin
      readdatavalid <= rd_acc;
      rd_hit_q      <= rd_hit;
      if (rd_acc) begin
        out_hit_q <= out_re;
        stat_q    <= (sel == SEL_W'(REG_STAT)) ?
                     DATA_W'({busy, result_ready, wr_err, idx}) : '0;
      end
    end
  end

  assign readdata = out_hit_q ? out_q : stat_q;

  always_comb begin
    lyr_rd_data = '0;
    for (int i = 0; i < NB; i++)
      if (rd_hit_q[i]) lyr_rd_data = bank_q[i];
  end
endmodule

// File: tb/tb_cnn_seq_mem.sv
// Bench for cnn_seq_mem: host register table, randomized bank/out traffic vs. array model, sequencer corners.
module tb_cnn_seq_mem;
  localparam int unsigned SZ [5] = '{6, 3, 5, 4, 7};
  localparam int OSZ = 16;

  logic        clk = 0, reset, chipselect, write, read;
  logic [18:0] address;
  logic [7:0]  writedata, readdata, lyr_rd_data, lyr_wr_data;
  logic        readdatavalid, lyr_rd_en, lyr_wr_en, busy, result_ready, wr_err;
  logic [3:0]  layer_start, layer_done, lyr_rd_region;
  logic [17:0] lyr_rd_addr, lyr_wr_addr;
  logic [4:0]  loaded;

  cnn_seq_mem #(.NUM_LAYERS(4), .REGION_SIZE(SZ), .OUT_SIZE(OSZ)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .readdatavalid(readdatavalid), .layer_start(layer_start), .layer_done(layer_done),
    .lyr_rd_en(lyr_rd_en), .lyr_rd_region(lyr_rd_region), .lyr_rd_addr(lyr_rd_addr),
    .lyr_rd_data(lyr_rd_data), .lyr_wr_en(lyr_wr_en), .lyr_wr_addr(lyr_wr_addr),
    .lyr_wr_data(lyr_wr_data), .loaded(loaded), .busy(busy),
    .result_ready(result_ready), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [7:0] mem_m [5][8];
  int         cnt_m [5];
  logic [7:0] out_m [OSZ];

  typedef struct {
    logic cs, wr, rd;
    logic [3:0] rg;
    logic [7:0] wd;
    logic exp_rdv;
    logic [7:0] exp_rd;
    logic exp_err;
  } vec_t;
  vec_t vecs [11];

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    chipselect = 0; write = 0; read = 0; lyr_rd_en = 0; lyr_wr_en = 0; layer_done = 0;
  endtask

  function automatic logic [18:0] mk(input logic [3:0] r, input int off);
    mk = {r, 15'(off)};
  endfunction

  function automatic logic [4:0] exp_loaded();
    for (int i = 0; i < 5; i++) exp_loaded[i] = (cnt_m[i] == int'(SZ[i]));
  endfunction

  task automatic clr_model();
    for (int i = 0; i < 5; i++) cnt_m[i] = 0;
  endtask

  task automatic hwrite(input logic [3:0] r, input logic [7:0] d);
    chipselect = 1; write = 1; address = mk(r, 0); writedata = d;
    tick(); idle();
  endtask

  task automatic hread(input logic [3:0] r, input int off, input logic [7:0] exp, input string nm);
    chipselect = 1; read = 1; address = mk(r, off);
    tick(); idle();
    chk({nm, "_v"}, readdatavalid, 1);
    chk(nm, readdata, exp);
  endtask

  // Fill every bank to capacity in random interleaved order, starting from the model's pointers.
  task automatic load_all();
    int left = 0;
    for (int i = 0; i < 5; i++) left += int'(SZ[i]) - cnt_m[i];
    while (left > 0) begin
      int r;
      logic [7:0] d;
      do r = $urandom_range(0, 4); while (cnt_m[r] == int'(SZ[r]));
      d = 8'($urandom);
      mem_m[r][cnt_m[r]] = d;
      cnt_m[r]++;
      left--;
      chipselect = 1; write = 1; address = mk(4'(r), $urandom_range(0, 200)); writedata = d;
      tick(); idle();
      chk("loaded", loaded, exp_loaded());
      chk("start_quiet", layer_start, 0);
    end
  endtask

  // Random operand reads, layer result writes and host OUT reads (with collisions).
  task automatic lyr_traffic(input int n, input bit live);
    for (int k = 0; k < n; k++) begin
      int r, a, ha, wa;
      bit hr, lw;
      logic [7:0] e, eh, wd;
      r  = $urandom_range(0, 6);
      a  = $urandom_range(0, 8);
      e  = 8'h00;
      if (r < 5) if (a < int'(SZ[r])) e = mem_m[r][a];
      ha = $urandom_range(0, OSZ - 1);
      hr = ($urandom_range(0, 1) == 1);
      lw = ($urandom_range(0, 1) == 1);
      wa = ($urandom_range(0, 2) == 0) ? ha : int'($urandom_range(0, OSZ - 1));
      wd = 8'($urandom);
      eh = out_m[ha];
      lyr_rd_en = 1; lyr_rd_region = 4'(r); lyr_rd_addr = 18'(a);
      lyr_wr_en = lw; lyr_wr_addr = 18'(wa); lyr_wr_data = wd;
      chipselect = hr; read = hr; write = 0; address = mk(4'hE, ha);
      tick();
      if (lw && live) out_m[wa] = wd;
      chk("lyr_rd", lyr_rd_data, e);
      chk("host_rdv", readdatavalid, hr);
      if (hr) chk("host_out", readdata, eh);
    end
    idle();
  endtask

  task automatic chk_reset_state();
    chk("rst_loaded", loaded, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", result_ready, 0);
    chk("rst_err", wr_err, 0);
    chk("rst_start", layer_start, 0);
    chk("rst_rdv", readdatavalid, 0);
    chk("rst_lyr_rd", lyr_rd_data, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle();
    reset = 0; address = '0; writedata = '0;
    lyr_rd_region = '0; lyr_rd_addr = '0; lyr_wr_addr = '0; lyr_wr_data = '0;
    clr_model();
    tick(); tick();
    chk_reset_state();
    chk("rst_readdata", readdata, 0);
    reset = 1;

    // cs wr rd region wdata | rdv rdata err
    vecs[0]  = '{1, 0, 1, 4'hD, 8'h00, 1, 8'h00, 0};
    vecs[1]  = '{1, 0, 1, 4'h2, 8'h00, 1, 8'h00, 0};
    vecs[2]  = '{1, 1, 0, 4'hC, 8'h11, 0, 8'h00, 1};
    vecs[3]  = '{1, 0, 1, 4'hD, 8'h00, 1, 8'h04, 1};
    vecs[4]  = '{1, 1, 1, 4'hD, 8'h00, 0, 8'h00, 1};
    vecs[5]  = '{0, 1, 0, 4'hF, 8'h01, 0, 8'h00, 1};
    vecs[6]  = '{1, 1, 0, 4'hF, 8'h00, 0, 8'h00, 1};
    vecs[7]  = '{1, 1, 0, 4'hF, 8'h01, 0, 8'h00, 0};
    vecs[8]  = '{1, 1, 0, 4'hE, 8'hAA, 0, 8'h00, 1};
    vecs[9]  = '{1, 1, 0, 4'hF, 8'h01, 0, 8'h00, 0};
    vecs[10] = '{1, 0, 1, 4'hD, 8'h00, 1, 8'h00, 0};
    for (int i = 0; i < 11; i++) begin
      chipselect = vecs[i].cs; write = vecs[i].wr; read = vecs[i].rd;
      address = mk(vecs[i].rg, 3); writedata = vecs[i].wd;
      tick(); idle();
      chk($sformatf("vec%0d_rdv", i), readdatavalid, vecs[i].exp_rdv);
      if (vecs[i].exp_rdv) chk($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), wr_err, vecs[i].exp_err);
    end
    chk("tbl_loaded", loaded, 0);

    // Fill all banks, then an extra input write lands on a full bank.
    load_all();
    chipselect = 1; write = 1; address = mk(4'h0, 0); writedata = 8'hEE;
    tick(); idle();
    chk("ld_start", layer_start, 4'b0001);
    chk("ld_err", wr_err, 1);
    chk("ld_loaded", loaded, 5'b11111);
    tick();
    chk("wait_start", layer_start, 0);
    chk("wait_busy", busy, 1);

    for (int a = 0; a < OSZ; a++) begin
      logic [7:0] d;
      d = 8'($urandom);
      lyr_wr_en = 1; lyr_wr_addr = 18'(a); lyr_wr_data = d; out_m[a] = d;
      tick();
    end
    idle();
    lyr_traffic(40, 1);

    layer_done = 4'b0100;
    tick(); idle();
    chk("stray_busy", busy, 1);
    chk("stray_start", layer_start, 0);
    hread(4'hD, 0, 8'h14, "stray_stat");

    lyr_wr_en = 1; lyr_wr_addr = 18'd7; lyr_wr_data = 8'hA5;
    tick(); idle();
    hread(4'hE, 7, 8'hA5, "out7");
    tick();
    chk("out7_pulse", readdatavalid, 0);
    lyr_wr_en = 1; lyr_wr_addr = 18'd7; lyr_wr_data = 8'h5A;
    chipselect = 1; read = 1; address = mk(4'hE, 7);
    tick(); idle();
    chk("coll_rdv", readdatavalid, 1);
    chk("coll_old", readdata, 8'hA5);
    out_m[7] = 8'h5A;
    hread(4'hE, 7, 8'h5A, "coll_new");

    // Advance to layer 2, then reset mid-run.
    layer_done = 4'b0001; tick(); idle();
    chk("run1_start1", layer_start, 4'b0010);
    tick();
    layer_done = 4'b0010; tick(); idle();
    chk("run1_start2", layer_start, 4'b0100);
    tick();
    hread(4'hD, 0, 8'h16, "idx2_stat");
    reset = 0; tick(); reset = 1;
    chk_reset_state();
    layer_done = 4'b0100; tick(); idle();
    chk("late_done_busy", busy, 0);
    chk("late_done_start", layer_start, 0);
    clr_model();
    lyr_traffic(20, 0);

    load_all();
    tick();
    chk("run2_start0", layer_start, 4'b0001);
    chk("run2_err", wr_err, 0);
    tick();
    lyr_traffic(20, 1);
    for (int k = 0; k < 4; k++) begin
      layer_done = 4'(1 << k);
      tick(); idle();
      chk($sformatf("step%0d_start", k), layer_start, (k < 3) ? (1 << (k + 1)) : 0);
      chk($sformatf("step%0d_ready", k), result_ready, k == 3);
      chk($sformatf("step%0d_busy", k), busy, k < 3);
      repeat (9) tick();
      chk($sformatf("step%0d_quiet", k), layer_start, 0);
    end
    lyr_traffic(10, 0);
    hwrite(4'h1, 8'h77);
    chk("done_wr_err", wr_err, 1);

    hwrite(4'hF, 8'h01);
    clr_model();
    chk("clr_ready", result_ready, 0);
    chk("clr_loaded", loaded, 0);
    chk("clr_err", wr_err, 0);
    chk("clr_busy", busy, 0);
    hwrite(4'h2, 8'h3C);
    mem_m[2][0] = 8'h3C;
    cnt_m[2] = 1;
    lyr_rd_en = 1; lyr_rd_region = 4'h2; lyr_rd_addr = 18'd0;
    tick(); idle();
    chk("clr_ptr0", lyr_rd_data, 8'h3C);
    load_all();
    tick();
    chk("run3_start0", layer_start, 4'b0001);
    tick();
    lyr_traffic(10, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
